counter_sequencer: RTL
======================

# counter_sequencer

- Run controller for the 8-bit up/down loadable counter.
- Accepts a run command (start value, limit, direction, repeat count) over a valid/ready handshake.
- Drives the counter's load/up/down/preset pins and watches its output.
- Flags the terminal count, signals completion, and holds the counter while idle or paused.
- Sits between the control logic and the counter; its clear is shared with the counter's clear.

## Interface
- WIDTH, 8, counter data width (q_in, cnt_preset, cmd_start, cmd_limit)
- REPW, 4, width of cmd_reps
- clock  in  1  single clock; all state updates on posedge
- clear  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_start  in  WIDTH  value loaded at pass start
- cmd_limit  in  WIDTH  terminal value of a pass
- cmd_dir  in  1  1 = count up, 0 = count down
- cmd_reps  in  REPW  extra passes; total passes = cmd_reps+1
- pause  in  1  freeze counter while RUN
- abort  in  1  terminate run, no done
- q_in  in  WIDTH  counter output
- cnt_load, cnt_up, cnt_down  out  1  counter controls
- cnt_preset  out  WIDTH  counter preset
- busy  out  1  state != IDLE
- tc  out  1  terminal count hit this cycle
- done  out  1  one-cycle completion pulse

## Operation
- The counter has no hold state: with load=0 it always counts, down when up=0.
- Hold is therefore implemented as cnt_load=1, cnt_preset=q_in.
- IDLE:
  - hold; cmd_ready=1.
  - On cmd_valid&cmd_ready: latch start/limit/dir, load rep_cnt=cmd_reps, go to LOAD.
- LOAD:
  - cnt_load=1, cnt_preset=start for one cycle, then RUN.
- RUN:
  - Default: cnt_load=0, cnt_up=dir, cnt_down=~dir.
  - Hit (q_in==limit and pause=0): tc=1 combinationally for that cycle.
  - Hit with rep_cnt!=0: cnt_load=1, cnt_preset=start, rep_cnt decrements, stay in RUN.
  - Hit with rep_cnt==0: hold, go to DONE.
- DONE:
  - Hold, done=1 for one cycle, then IDLE.
- pause=1 in RUN:
  - Hold and suppress hit evaluation.
  - A pending hit is taken in the first cycle after pause drops.
  - pause is ignored outside RUN.
- abort=1 in LOAD, RUN or DONE:
  - Next edge goes to IDLE with no done.
  - Hold in the abort cycle.
  - abort outranks pause and hit, but tc still reflects the hit.
- Arithmetic is modulo 2^WIDTH.
  - Counts wrap 255->0 (up) and 0->255 (down).
  - The limit is always reached.
- start==limit: hit in the first RUN cycle; pass length 1.
- Reset values: IDLE, busy=0, cmd_ready=1, tc=0, done=0, cnt_load=1, cnt_up=0, cnt_down=0, cnt_preset=q_in (0 after shared clear), rep_cnt=0.
- clear mid-run: immediate return to IDLE; latched command discarded.

## Timing
- Edge E0 accepts the command.
- LOAD occupies E0..E1; counter holds start from E1.
- Up pass: tc rises in the cycle after edge E1+((limit-start) mod 2^WIDTH).
- Down pass: same, using (start-limit) mod 2^WIDTH.
- Each repeat adds (distance+1) cycles: the hit cycle reloads start.
- done is high the cycle after the final tc.
- cmd_ready returns the cycle after done.
- Back-to-back commands: minimum gap of one IDLE cycle after done.
- All outputs are state-registered except tc, cnt_load and cnt_preset, which are combinational from state, q_in and pause.

## Configuration
- BOUNCE_MODE_EN defined:
  - Adds cmd_bounce input (1 bit).
  - When the latched bounce=1, a non-final hit swaps start/limit and inverts dir instead of reloading.
  - Counting continues from the current value, so there is no reload cycle.
  - Passes are still counted by rep_cnt.
- BOUNCE_MODE_EN undefined:
  - No cmd_bounce port.
  - Every non-final hit reloads start.

## Test plan
- Simple up run: clear; start=3, limit=7, dir=1, reps=0 -> q 3,4,5,6,7; tc high one cycle at q=7; done next cycle; q held at 7; cmd_ready=1 afterwards.
- Down with wrap: start=2, limit=254, dir=0 -> q 2,1,0,255,254; tc at 254; done.
- Repeats: start=0, limit=2, dir=1, reps=2 -> q 0,1,2,0,1,2,0,1,2; three tc pulses; one done.
- Pause then abort: start=10, limit=20, up; pause for 4 cycles at q=14 -> q stays 14, no tc; then abort at q=17 -> IDLE, q held at 17, done never asserts.
- Edge cases: start=limit=5 -> tc in first RUN cycle, done next. cmd_valid while busy -> cmd_ready=0, command not taken. clear asserted mid-run -> outputs at reset values immediately.
- BOUNCE_MODE_EN: start=1, limit=3, up, reps=1, bounce=1 -> q 1,2,3,2,1; tc at the first 3 and at the final 1; done.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// ============================================================================
// Module   : counter_sequencer_if
// Purpose  : Run-command valid/ready bus for counter_sequencer.
//            BOUNCE_MODE_EN adds the cmd_bounce field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int REPW  = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_limit;
  logic             cmd_dir;
  logic [REPW-1:0]  cmd_reps;
`ifdef BOUNCE_MODE_EN
  logic             cmd_bounce;

  modport master (
    output cmd_valid, cmd_start, cmd_limit, cmd_dir, cmd_reps, cmd_bounce,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_start, cmd_limit, cmd_dir, cmd_reps, cmd_bounce,
    output cmd_ready
  );
`else
  modport master (
    output cmd_valid, cmd_start, cmd_limit, cmd_dir, cmd_reps,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_start, cmd_limit, cmd_dir, cmd_reps,
    output cmd_ready
  );
`endif
endinterface

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
// Module   : counter_sequencer
// Purpose  : Run controller for an 8-bit up/down loadable counter.
//            Optional BOUNCE_MODE_EN: non-final hits reverse direction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int REPW  = 4
) (
  input  wire logic             clock,
  input  wire logic             clear,
  counter_sequencer_if.slave    cmd,
  input  wire logic             pause,
  input  wire logic             abort,
  input  wire logic [WIDTH-1:0] q_in,
  output logic                  cnt_load,
  output logic                  cnt_up,
  output logic                  cnt_down,
  output logic [WIDTH-1:0]      cnt_preset,
  output logic                  busy,
  output logic                  tc,
  output logic                  done
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir;
  logic [REPW-1:0]  r_rep_cnt;
  logic             w_accept;
  logic             w_hit;
  logic             w_repeat;
`ifdef BOUNCE_MODE_EN
  logic             r_bounce;
`endif

  // State register plus the latched command fields
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= c_st_idle;
      r_start   <= '0;
      r_limit   <= '0;
      r_dir     <= 1'b0;
      r_rep_cnt <= '0;
`ifdef BOUNCE_MODE_EN
      r_bounce  <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_start   <= cmd.cmd_start;
        r_limit   <= cmd.cmd_limit;
        r_dir     <= cmd.cmd_dir;
        r_rep_cnt <= cmd.cmd_reps;
`ifdef BOUNCE_MODE_EN
        r_bounce  <= cmd.cmd_bounce;
`endif
      end else if (w_repeat) begin
        r_rep_cnt <= r_rep_cnt - REPW'(1);
`ifdef BOUNCE_MODE_EN
        if (r_bounce) begin
          r_start <= r_limit;
          r_limit <= r_start;
          r_dir   <= ~r_dir;
        end
`endif
      end
    end
  end

  always_comb begin
    w_accept     = (r_state == c_st_idle) && cmd.cmd_valid;
    w_hit        = (r_state == c_st_run) && !pause && (q_in == r_limit);
    w_repeat     = w_hit && !abort && (r_rep_cnt != '0);
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_next_state = c_st_load;
      c_st_load: w_next_state = abort ? c_st_idle : c_st_run;
      c_st_run: begin
        if (abort)
          w_next_state = c_st_idle;
        else if (w_hit && (r_rep_cnt == '0))
          w_next_state = c_st_done;
      end
      c_st_done: w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // The counter cannot stop on its own, so "hold" means reloading q_in
  always_comb begin
    cnt_load      = 1'b1;
    cnt_preset    = q_in;
    cnt_up        = 1'b0;
    cnt_down      = 1'b0;
    tc            = 1'b0;
    busy          = (r_state != c_st_idle);
    done          = (r_state == c_st_done);
    cmd.cmd_ready = (r_state == c_st_idle);
    case (r_state)
      c_st_load: if (!abort) cnt_preset = r_start;
      c_st_run: begin
        cnt_up   = r_dir;
        cnt_down = ~r_dir;
        tc       = w_hit;
        if (!abort && !pause && !w_hit) begin
          cnt_load = 1'b0;
        end else if (w_repeat) begin
`ifdef BOUNCE_MODE_EN
          if (r_bounce) begin
            // Turn around on the spot: count away from the old limit now
            cnt_load = 1'b0;
            cnt_up   = ~r_dir;
            cnt_down = r_dir;
          end else begin
            cnt_preset = r_start;
          end
`else
          cnt_preset = r_start;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
